// File: rtl/fdiv_issue_if.sv
// Handshake bundle between the core, the pipelined float divider and writeback.
// The issue unit takes the slave view; the surrounding environment takes the master view.
interface fdiv_issue_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_x1;
  logic [31:0]      req_x2;
  logic [TAG_W-1:0] req_tag;

  logic             div_valid;
  logic [31:0]      div_x1;
  logic [31:0]      div_x2;
  logic [31:0]      div_y;
  logic             div_ovf;
  logic             div_unf;
  logic             div_out_valid;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_y;
  logic [TAG_W-1:0] res_tag;
  logic [2:0]       res_flags;

  modport slave (
    input  req_valid, req_x1, req_x2, req_tag,
    output req_ready,
    output div_valid, div_x1, div_x2,
    input  div_y, div_ovf, div_unf, div_out_valid,
    output res_valid, res_y, res_tag, res_flags,
    input  res_ready
  );

  modport master (
    output req_valid, req_x1, req_x2, req_tag,
    input  req_ready,
    input  div_valid, div_x1, div_x2,
    output div_y, div_ovf, div_unf, div_out_valid,
    input  res_valid, res_y, res_tag, res_flags,
    output res_ready
  );
endinterface

// File: rtl/fdiv_issue_unit.sv
// Issues tagged divide requests into a non-stallable float divider and collects its
// results, in issue order, into a result buffer. Credits bound in-flight + buffered ops.
module fdiv_issue_unit #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        rstn,
  fdiv_issue_if.slave bus,
  output logic        busy,
  output logic        err_unexpected
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             dz;
  } tag_entry_t;

  typedef struct packed {
    logic [31:0]      y;
    logic             dz;
    logic             ovf;
    logic             unf;
    logic [TAG_W-1:0] tag;
  } res_entry_t;

  logic [CW-1:0] credits;
  logic          accept;

  tag_entry_t    tag_mem [DEPTH];
  logic [PW-1:0] tag_wptr, tag_rptr;
  logic [CW-1:0] tag_count;
  logic          tag_empty;
  tag_entry_t    tag_head;

  res_entry_t    res_mem [DEPTH];
  logic [PW-1:0] res_wptr, res_rptr;
  logic [CW-1:0] res_count;
  logic          res_empty, res_full;
  logic          res_push, res_pop;
  res_entry_t    res_head;

  // req_ready depends only on the credit register, so no combinational path
  // exists from req_valid back to req_ready.
  assign bus.req_ready = (credits != '0);
  assign accept        = bus.req_valid & bus.req_ready;
  assign busy          = (credits != FULL_CNT);

  assign tag_empty = (tag_count == '0);
  assign tag_head  = tag_mem[tag_rptr];
  // A result with no matching tag is dropped rather than buffered.
  assign res_push  = bus.div_out_valid & ~tag_empty;

  assign res_empty = (res_count == '0);
  assign res_full  = (res_count == FULL_CNT);
  assign res_pop   = ~res_empty & bus.res_ready;
  assign res_head  = res_mem[res_rptr];

  assign bus.res_valid = ~res_empty;
  assign bus.res_y     = res_head.y;
  assign bus.res_tag   = res_head.tag;
  assign bus.res_flags = {res_head.dz, res_head.ovf, res_head.unf};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of always_ff evaluation order.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      credits <= FULL_CNT;
    end else if (accept && !res_pop) begin
      credits <= credits - CW'(1);
    end else if (res_pop && !accept) begin
      credits <= credits + CW'(1);
    end
  end

  // Divider input stage: valid pulses for one cycle, operands hold when idle.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      bus.div_valid <= 1'b0;
      bus.div_x1    <= '0;
      bus.div_x2    <= '0;
    end else begin
      bus.div_valid <= accept;
      if (accept) begin
        bus.div_x1 <= bus.req_x1;
        bus.div_x2 <= bus.req_x2;
      end
    end
  end

  // NOTE: FIFO storage has no reset; pointers and counts alone define which
  // entries are valid, so clearing the arrays would only cost flops.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      tag_mem[tag_wptr] <= '{tag: bus.req_tag, dz: (bus.req_x2[30:23] == 8'd0)};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      tag_wptr  <= '0;
      tag_rptr  <= '0;
      tag_count <= '0;
    end else begin
      if (accept)   tag_wptr <= tag_wptr + PW'(1);
      if (res_push) tag_rptr <= tag_rptr + PW'(1);
      case ({accept, res_push})
        2'b10:   tag_count <= tag_count + CW'(1);
        2'b01:   tag_count <= tag_count - CW'(1);
        default: tag_count <= tag_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (res_push) begin
      res_mem[res_wptr] <= '{y:   bus.div_y,
                             dz:  tag_head.dz,
                             ovf: bus.div_ovf,
                             unf: bus.div_unf,
                             tag: tag_head.tag};
    end
  end

  // Push and pop together leave occupancy unchanged, even when full.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      res_wptr  <= '0;
      res_rptr  <= '0;
      res_count <= '0;
    end else begin
      if (res_push) res_wptr <= res_wptr + PW'(1);
      if (res_pop)  res_rptr <= res_rptr + PW'(1);
      case ({res_push, res_pop})
        2'b10:   res_count <= res_count + CW'(1);
        2'b01:   res_count <= res_count - CW'(1);
        default: res_count <= res_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      err_unexpected <= 1'b0;
    end else if (bus.div_out_valid && tag_empty) begin
      err_unexpected <= 1'b1;
    end
  end

  // Credits make this unreachable; a hit means admission control is broken.
  res_no_overflow: assert property (@(posedge sys_clk) disable iff (!rstn)
    !(res_push && res_full && !res_pop));

endmodule

// File: tb/tb_fdiv_issue_unit.sv
// Self-checking bench: fixed-latency divider model, queue-based reference of the
// issue/collect rules, directed vector table, corner sequences and random traffic.
module tb_fdiv_issue_unit;
  localparam int TAG_W = 5;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic sys_clk = 1'b0;
  logic rstn    = 1'b0;
  logic busy, err_unexpected;
  logic force_out = 1'b0;

  fdiv_issue_if #(.TAG_W(TAG_W)) bus ();

  fdiv_issue_unit #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .sys_clk        (sys_clk),
    .rstn           (rstn),
    .bus            (bus),
    .busy           (busy),
    .err_unexpected (err_unexpected)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference float divide: returns {y, ovf, unf}. Zero/denormal divisor gives signed inf.
  function automatic logic [33:0] fdiv_ref(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [10:0] ea, eb;
    logic [63:0] qb;
    real         ra, rb;
    int          e;
    s = a[31] ^ b[31];
    if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0, 2'b00};
    if (a[30:23] == 8'd0) return {s, 31'd0, 2'b00};
    ea = 11'(a[30:23]) + 11'd896;
    eb = 11'(b[30:23]) + 11'd896;
    ra = $bitstoreal({1'b0, ea, a[22:0], 29'd0});
    rb = $bitstoreal({1'b0, eb, b[22:0], 29'd0});
    qb = $realtobits(ra / rb);
    e  = int'(qb[62:52]) - 896;
    if (e > 254) return {s, 8'hFF, 23'd0, 2'b10};
    if (e < 1)   return {s, 31'd0, 2'b01};
    return {s, 8'(e), qb[51:29], 2'b00};
  endfunction

  // Fixed-latency divider with no stall input; shares the reset.
  logic [LAT-1:0] pv;
  logic [31:0]    pa [LAT];
  logic [31:0]    pb [LAT];

  always @(posedge sys_clk) begin
    if (!rstn) pv <= '0;
    else       pv <= {pv[LAT-2:0], bus.div_valid};
    pa[0] <= bus.div_x1;
    pb[0] <= bus.div_x2;
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end

  assign {bus.div_y, bus.div_ovf, bus.div_unf} = fdiv_ref(pa[LAT-1], pb[LAT-1]);
  assign bus.div_out_valid = pv[LAT-1] | force_out;

  // Reference model: every accepted request owes exactly one result, in order.
  typedef struct {
    logic [31:0]      y;
    logic [2:0]       flags;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             q [$];
  logic [TAG_W-1:0] popped_tags [$];
  int               outstanding = 0;
  int               acc_cnt = 0;
  logic             exp_dv = 1'b0;
  logic             exp_err = 1'b0;
  logic [31:0]      exp_dx1 = '0;
  logic [31:0]      exp_dx2 = '0;

  always @(negedge sys_clk) begin
    if (!rstn) begin
      q.delete();
      outstanding = 0;
      exp_dv  = 1'b0;
      exp_dx1 = '0;
      exp_dx2 = '0;
      exp_err = 1'b0;
    end else begin
      logic        acc;
      logic [33:0] r;
      check("req_ready", bus.req_ready, outstanding < DEPTH);
      check("busy", busy, outstanding != 0);
      check("err_unexpected", err_unexpected, exp_err);
      check("div_valid", bus.div_valid, exp_dv);
      check("div_x1", bus.div_x1, exp_dx1);
      check("div_x2", bus.div_x2, exp_dx2);
      if (q.size() == 0) begin
        check("res_valid_no_op", bus.res_valid, 1'b0);
      end else if (bus.res_valid) begin
        check("res_y", bus.res_y, q[0].y);
        check("res_flags", bus.res_flags, q[0].flags);
        check("res_tag", bus.res_tag, q[0].tag);
        if (bus.res_ready) begin
          popped_tags.push_back(bus.res_tag);
          void'(q.pop_front());
          outstanding--;
        end
      end
      acc = bus.req_valid & bus.req_ready;
      if (acc) begin
        r = fdiv_ref(bus.req_x1, bus.req_x2);
        q.push_back('{y: r[33:2], flags: {bus.req_x2[30:23] == 8'd0, r[1], r[0]},
                      tag: bus.req_tag});
        outstanding++;
        acc_cnt++;
        exp_dx1 = bus.req_x1;
        exp_dx2 = bus.req_x2;
      end
      exp_dv = acc;
      if (force_out) exp_err = 1'b1;
    end
  end

  typedef struct {
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] tag;
    logic [31:0]      y;
    logic [2:0]       flags;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [31:0] x1, input logic [31:0] x2,
                         input logic [TAG_W-1:0] tag);
    bus.req_valid = v;
    bus.req_x1    = x1;
    bus.req_x2    = x2;
    bus.req_tag   = tag;
  endtask

  task automatic wait_idle(input string name);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (!busy && q.size() == 0) break;
      step();
    end
    if (busy || q.size() != 0) check({name, "_drain_timeout"}, busy, 1'b0);
  endtask

  function automatic logic [31:0] rand_float();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  initial begin
    int base;

    vecs[0] = '{32'h40C00000, 32'h40000000, 5'd3,  32'h40400000, 3'b000};
    vecs[1] = '{32'h3F800000, 32'h00000000, 5'd7,  32'h7F800000, 3'b100};
    vecs[2] = '{32'h41000000, 32'h3F000000, 5'd12, 32'h41800000, 3'b000};
    vecs[3] = '{32'hC1100000, 32'h40400000, 5'd31, 32'hC0400000, 3'b000};
    vecs[4] = '{32'h7F000000, 32'h3E800000, 5'd0,  32'h7F800000, 3'b010};
    vecs[5] = '{32'h00800000, 32'h40000000, 5'd18, 32'h00000000, 3'b001};

    set_req(1'b0, '0, '0, '0);
    bus.res_ready = 1'b0;
    repeat (3) step();
    check("rst_div_valid", bus.div_valid, 1'b0);
    check("rst_div_x1", bus.div_x1, 32'd0);
    check("rst_div_x2", bus.div_x2, 32'd0);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_unexpected, 1'b0);
    check("rst_req_ready", bus.req_ready, 1'b1);
    rstn = 1'b1;
    step();

    // Directed single ops, one at a time, each held until read.
    for (int v = 0; v < 6; v++) begin
      bus.res_ready = 1'b0;
      set_req(1'b1, vecs[v].x1, vecs[v].x2, vecs[v].tag);
      step();
      set_req(1'b0, '0, '0, '0);
      for (int i = 0; i < 20; i++) begin
        if (bus.res_valid) break;
        step();
      end
      check("vec_res_valid", bus.res_valid, 1'b1);
      check("vec_res_y", bus.res_y, vecs[v].y);
      check("vec_res_tag", bus.res_tag, vecs[v].tag);
      check("vec_res_flags", bus.res_flags, vecs[v].flags);
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      check("vec_busy_after", busy, 1'b0);
    end

    // Back-to-back issue of tags 1..4.
    popped_tags.delete();
    bus.res_ready = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      set_req(1'b1, {1'b0, 8'(128 + t), 23'(t * 1000)}, {1'b0, 8'(126 + t), 23'd0}, 5'(t));
      step();
      check("b2b_div_valid", bus.div_valid, 1'b1);
    end
    set_req(1'b0, '0, '0, '0);
    step();
    check("b2b_div_valid_drop", bus.div_valid, 1'b0);
    wait_idle("b2b");
    check("b2b_count", popped_tags.size(), 4);
    for (int t = 0; t < 4 && t < popped_tags.size(); t++)
      check("b2b_order", popped_tags[t], 5'(t + 1));

    // Backpressure: only DEPTH accepted while writeback stalls.
    popped_tags.delete();
    bus.res_ready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 12; i++) begin
      set_req(1'b1, rand_float(), rand_float(), 5'(1 + acc_cnt - base));
      step();
    end
    check("bp_accepted", acc_cnt - base, 4);
    check("bp_req_ready_low", bus.req_ready, 1'b0);
    check("bp_res_valid", bus.res_valid, 1'b1);
    check("bp_head_tag", bus.res_tag, 5'd1);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("bp_req_ready_back", bus.req_ready, 1'b1);
    check("bp_popped_tag1", popped_tags.size() == 1 && popped_tags[0] == 5'd1, 1'b1);
    step();
    check("bp_req5_accepted", acc_cnt - base, 5);
    set_req(1'b0, '0, '0, '0);
    wait_idle("bp");

    // Accept and pop in the same cycle at credits=1.
    bus.res_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      set_req(1'b1, rand_float(), rand_float(), 5'(20 + t));
      step();
    end
    set_req(1'b0, '0, '0, '0);
    repeat (8) step();
    check("sim_pre_ready", bus.req_ready, 1'b1);
    check("sim_pre_res_valid", bus.res_valid, 1'b1);
    set_req(1'b1, 32'h40C00000, 32'h40000000, 5'd9);
    bus.res_ready = 1'b1;
    step();
    set_req(1'b0, '0, '0, '0);
    bus.res_ready = 1'b0;
    check("sim_post_ready", bus.req_ready, 1'b1);
    check("sim_post_busy", busy, 1'b1);
    step();
    check("sim_ready_holds", bus.req_ready, 1'b1);
    wait_idle("sim");

    // Reset with three ops in flight, then a stray divider result.
    bus.res_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      set_req(1'b1, rand_float(), rand_float(), 5'(25 + t));
      step();
    end
    set_req(1'b0, '0, '0, '0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("rmid_res_valid", bus.res_valid, 1'b0);
    end
    check("rmid_req_ready", bus.req_ready, 1'b1);
    check("rmid_busy", busy, 1'b0);
    check("rmid_err_clear", err_unexpected, 1'b0);
    force_out = 1'b1;
    step();
    force_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("err_sticky", err_unexpected, 1'b1);
    end
    check("err_no_result", bus.res_valid, 1'b0);

    // Clear the sticky error before random traffic.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    check("err_cleared_by_reset", err_unexpected, 1'b0);

    // Random traffic against the reference queue, with phases of heavy backpressure.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] x2;
      x2 = ($urandom_range(0, 7) == 0) ? {1'($urandom_range(0, 1)), 8'd0, 23'($urandom_range(0, 3))}
                                       : rand_float();
      set_req(1'($urandom_range(0, 1)), rand_float(), x2, 5'($urandom));
      bus.res_ready = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                           : ($urandom_range(0, 4) == 0);
      step();
    end
    set_req(1'b0, '0, '0, '0);
    wait_idle("rand");
    check("final_queue_empty", q.size(), 0);
    check("final_err", err_unexpected, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
